// File: rtl/mem_req_unit.sv
// mem_req_unit: load/store bus request unit; ports: ex_*/is_*/size/addr/wdata op in, da_* lane-enabled bus, ld_* extended load out, busy stall, ale alignment-error pulse
module mem_req_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   da_ren,
  output logic [DATA_W/8-1:0]   da_wen,
  output logic [ADDR_W-1:0]     da_addr,
  output logic [DATA_W-1:0]     da_wdata,
  input  logic                  da_ready,
  input  logic                  da_rvalid,
  input  logic [DATA_W-1:0]     da_rdata,
  output logic                  ld_valid,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  busy,
  output logic                  ale
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e state_q;
  logic [1:0] size_q;
  logic sext_q;
  logic [OW-1:0] off_q;
  logic [NB-1:0] da_ren_q, da_wen_q, base, mask_d;
  logic [ADDR_W-1:0] da_addr_q;
  logic [DATA_W-1:0] da_wdata_q, ld_data_q, wdata_d, sh, keep, ld_data_d;
  logic ld_valid_q, ale_q, mis, sgn;
  always_comb begin
    base = size == 2'd0 ? NB'(1) : size == 2'd1 ? NB'(3) : size == 2'd2 ? NB'(15) : '1;
    mask_d = base << addr[OW-1:0];
    mis = int'(size) > OW || (addr[OW-1:0] & ((OW'(1) << size) - OW'(1))) != '0;
    wdata_d = size == 2'd0 ? {NB{wdata[7:0]}} : size == 2'd1 ? {(NB/2){wdata[15:0]}} :
              size == 2'd2 ? {(NB/4){wdata[31:0]}} : wdata;
    sh = da_rdata >> {off_q, 3'b000};
    keep = size_q == 2'd0 ? DATA_W'(8'hFF) : size_q == 2'd1 ? DATA_W'(16'hFFFF) :
           size_q == 2'd2 ? DATA_W'(32'hFFFF_FFFF) : '1;
    sgn = sext_q & (size_q == 2'd0 ? sh[7] : size_q == 2'd1 ? sh[15] : size_q == 2'd2 ? sh[31] : sh[DATA_W-1]);
    ld_data_d = (sh & keep) | (sgn ? ~keep : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      size_q     <= '0;
      sext_q     <= 1'b0;
      off_q      <= '0;
      da_ren_q   <= '0;
      da_wen_q   <= '0;
      da_addr_q  <= '0;
      da_wdata_q <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      ale_q      <= 1'b0;
    end else begin
      ale_q      <= 1'b0;
      ld_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (ex_valid && (is_load || is_store)) begin
          if (mis) ale_q <= 1'b1;
          else begin
            state_q    <= REQ;
            da_ren_q   <= is_store ? '0 : mask_d;
            da_wen_q   <= is_store ? mask_d : '0;
            da_addr_q  <= {addr[ADDR_W-1:OW], OW'(0)};
            da_wdata_q <= wdata_d;
            size_q     <= size;
            sext_q     <= sign_ext;
            off_q      <= addr[OW-1:0];
          end
        end
        REQ: if (da_ready) begin
          state_q  <= |da_wen_q ? IDLE : WAIT;
          da_ren_q <= '0;
          da_wen_q <= '0;
        end
        WAIT: if (da_rvalid) begin
          state_q    <= IDLE;
          ld_valid_q <= 1'b1;
          ld_data_q  <= ld_data_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign da_ren   = da_ren_q;
  assign da_wen   = da_wen_q;
  assign da_addr  = da_addr_q;
  assign da_wdata = da_wdata_q;
  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;
  assign ale      = ale_q;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_mem_req_unit.sv
// tb_mem_req_unit: randomized scoreboard bench for a 32-bit mem_req_unit plus a directed 64-bit instance
module tb_mem_req_unit;
  localparam int K_REQ = 0;
  localparam int K_ALE = 1;
  localparam int K_LD  = 2;
  typedef struct {
    int          kind;
    logic [3:0]  ren;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ld;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_valid = 1'b0, is_load = 1'b0, is_store = 1'b0, sign_ext = 1'b0;
  logic [1:0] size = 2'd0;
  logic [31:0] addr = '0, wdata = '0, da_addr, da_wdata, da_rdata = '0, ld_data;
  logic [3:0] da_ren, da_wen;
  logic da_ready = 1'b0, da_rvalid = 1'b0, ld_valid, busy, ale;
  logic w_ex_valid = 1'b0, w_ready = 1'b0, w_rvalid = 1'b0;
  logic [7:0] w_ren, w_wen;
  logic [31:0] w_addr = '0, w_da_addr;
  logic [63:0] w_da_wdata, w_rdata = '0, w_ld_data;
  logic w_ld_valid, w_busy, w_ale;
  exp_t sbq[$];
  exp_t f;
  int checks = 0, errors = 0, req_cyc = 0, acc = 0, kind;
  logic [3:0] last_ren, last_wen;
  logic [31:0] last_addr, last_wdata;
  always #5 clk = ~clk;
  mem_req_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .is_load(is_load), .is_store(is_store),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .da_ren(da_ren), .da_wen(da_wen), .da_addr(da_addr), .da_wdata(da_wdata),
    .da_ready(da_ready), .da_rvalid(da_rvalid), .da_rdata(da_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .busy(busy), .ale(ale)
  );
  mem_req_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .ex_valid(w_ex_valid), .is_load(1'b1), .is_store(1'b0),
    .size(2'd0), .sign_ext(1'b0), .addr(w_addr), .wdata(64'd0),
    .da_ren(w_ren), .da_wen(w_wen), .da_addr(w_da_addr), .da_wdata(w_da_wdata),
    .da_ready(w_ready), .da_rvalid(w_rvalid), .da_rdata(w_rdata),
    .ld_valid(w_ld_valid), .ld_data(w_ld_data), .busy(w_busy), .ale(w_ale)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask
  function automatic exp_t model_req(input bit st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int n = 1 << sz;
    int off = int'(a[1:0]);
    logic [3:0] m = '0;
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) m = m | (4'(1) << i);
      r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    end
    e.kind  = (sz == 2'd3 || (a % n) != 0) ? K_ALE : K_REQ;
    e.ren   = st ? 4'd0 : m;
    e.wen   = st ? m : 4'd0;
    e.addr  = a & ~32'h3;
    e.wdata = r;
    e.ld    = '0;
    return e;
  endfunction
  function automatic logic [31:0] model_ld(input logic [1:0] sz, input bit sx, input logic [31:0] a, input logic [31:0] rd);
    int n = 1 << sz;
    logic [31:0] v = rd >> (8 * int'(a[1:0]));
    logic [31:0] k;
    if (n < 4) begin
      k = (32'h1 << (8 * n)) - 32'h1;
      v = (v & k) | ((sx && v[8*n-1]) ? ~k : 32'h0);
    end
    return v;
  endfunction
  task automatic noise(input bit en);
    ex_valid = en;
    if (en) begin
      is_load  = 1'b1;
      is_store = 1'($urandom % 2);
      size     = 2'($urandom % 3);
      addr     = $urandom;
      wdata    = $urandom;
    end
  endtask
  task automatic issue(input bit st, input logic [1:0] sz, input bit sx, input logic [31:0] a, input logic [31:0] wd, output bit mis);
    exp_t e = model_req(st, sz, a, wd);
    mis = e.kind == K_ALE;
    sbq.push_back(e);
    @(posedge clk); #1;
    ex_valid = 1'b1;
    is_store = st;
    is_load  = st ? 1'($urandom % 2) : 1'b1;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    wdata    = wd;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask
  task automatic op(input bit st, input logic [1:0] sz, input bit sx, input logic [31:0] a, input logic [31:0] wd,
                    input int rdly, input int vdly, input logic [31:0] rd, input bit nz);
    exp_t e;
    bit mis;
    issue(st, sz, sx, a, wd, mis);
    if (mis) begin
      @(posedge clk); #1;
      return;
    end
    for (int k = 0; k < rdly; k++) begin
      da_ready = 1'b0;
      noise(nz);
      @(posedge clk); #1;
    end
    da_ready = 1'b1;
    da_rvalid = nz;
    da_rdata = ~rd;
    noise(nz);
    @(posedge clk); #1;
    da_ready = 1'b0;
    da_rvalid = 1'b0;
    ex_valid = 1'b0;
    if (st) return;
    for (int k = 0; k < vdly; k++) begin
      noise(nz);
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    e = '{kind: K_LD, ren: 4'd0, wen: 4'd0, addr: 32'd0, wdata: 32'd0, ld: model_ld(sz, sx, a, rd)};
    sbq.push_back(e);
    da_rvalid = 1'b1;
    da_rdata = rd;
    @(posedge clk); #1;
    da_rvalid = 1'b0;
    da_rdata = $urandom;
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (!rst && (ale || ld_valid || da_ren != 4'd0 || da_wen != 4'd0)) begin
      kind = ale ? K_ALE : ld_valid ? K_LD : K_REQ;
      f = sbq.size() > 0 ? sbq[0] : '{kind: -1, ren: 4'd0, wen: 4'd0, addr: 32'd0, wdata: 32'd0, ld: 32'd0};
      chk("event_kind", 64'(kind), 64'(f.kind));
      if (kind == f.kind) begin
        if (kind == K_REQ) begin
          chk("da_ren", da_ren, f.ren);
          chk("da_wen", da_wen, f.wen);
          chk("da_addr", da_addr, f.addr);
          chk("da_wdata", da_wdata, f.wdata);
          req_cyc++;
          last_ren = da_ren;
          last_wen = da_wen;
          last_addr = da_addr;
          last_wdata = da_wdata;
          if (da_ready) begin
            acc++;
            void'(sbq.pop_front());
          end
        end else begin
          if (kind == K_LD) chk("ld_data", ld_data, f.ld);
          void'(sbq.pop_front());
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int r0, a0;
    bit st, mis;
    logic [1:0] sz;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ren", da_ren, 0);
    chk("rst_wen", da_wen, 0);
    chk("rst_addr", da_addr, 0);
    chk("rst_wdata", da_wdata, 0);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ale", ale, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    op(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 0, 0, 0, 1'b0);
    chk("sb_addr", last_addr, 32'h1000);
    chk("sb_wen", last_wen, 4'b1000);
    chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    chk("sb_busy_after", busy, 0);
    chk("sb_wen_after", da_wen, 0);
    r0 = req_cyc;
    op(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 3, 0, 32'h8001_1234, 1'b0);
    chk("lh_ren", last_ren, 4'b1100);
    chk("lh_req_cycles", 64'(req_cyc - r0), 4);
    chk("lh_ld_data", ld_data, 32'hFFFF_8001);
    r0 = req_cyc;
    op(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 0, 0, 0, 1'b0);
    chk("ale_busy", busy, 0);
    chk("ale_no_req", 64'(req_cyc - r0), 0);
    a0 = acc;
    op(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 2, 2, 32'hCAFE_F00D, 1'b1);
    chk("busy_one_req", 64'(acc - a0), 1);
    chk("busy_ld_data", ld_data, 32'hCAFE_F00D);
    issue(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, mis);
    da_ready = 1'b1;
    @(posedge clk); #1;
    da_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    da_rvalid = 1'b1;
    da_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    da_rvalid = 1'b0;
    @(negedge clk);
    chk("wrst_ren", da_ren, 0);
    chk("wrst_addr", da_addr, 0);
    chk("wrst_wdata", da_wdata, 0);
    chk("wrst_ld_valid", ld_valid, 0);
    chk("wrst_ld_data", ld_data, 0);
    chk("wrst_busy", busy, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 80; i++) begin
      st = 1'($urandom % 2);
      sz = 2'($urandom % 4);
      a = $urandom;
      if ($urandom % 4 != 0) a = a & ~((32'h1 << sz) - 32'h1);
      op(st, sz, 1'($urandom % 2), a, $urandom, int'($urandom % 4), int'($urandom % 4), $urandom, 1'($urandom % 2));
    end
    w_addr = 32'h47;
    w_ex_valid = 1'b1;
    @(posedge clk); #1;
    w_ex_valid = 1'b0;
    w_ready = 1'b1;
    @(negedge clk);
    chk("w64_ren", w_ren, 8'h80);
    chk("w64_addr", w_da_addr, 32'h40);
    @(posedge clk); #1;
    w_ready = 1'b0;
    w_rvalid = 1'b1;
    w_rdata = 64'h9A00_0000_0000_0000;
    @(posedge clk); #1;
    w_rvalid = 1'b0;
    @(negedge clk);
    chk("w64_ld_valid", w_ld_valid, 1);
    chk("w64_ld_data", w_ld_data, 64'h9A);
    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_req_unit.md
MEM_REQ_UNIT -- requirements
Module: mem_req_unit

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data-bus width (legal: 32, 64); NB = DATA_W/8 byte lanes, OW = log2(NB).
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-003 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 ex_valid  in  1  SHALL be a one-cycle pulse presenting a new mem-stage operation.
REQ-006 is_load  in  1 / is_store  in  1  SHALL be the operation class.
REQ-007 size  in  2  SHALL be the access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-008 sign_ext  in  1  SHALL select sign (1) or zero (0) extension for loads.
REQ-009 addr  in  ADDR_W  SHALL be the byte address; wdata  in  DATA_W  SHALL be the store data, LSB-aligned.
REQ-010 da_ren / da_wen  out  NB  SHALL be the per-lane read/write enables.
REQ-011 da_addr  out  ADDR_W / da_wdata  out  DATA_W  SHALL be the bus address and lane-placed data.
REQ-012 da_ready  in  1  SHALL indicate that the bus accepts the request in this cycle.
REQ-013 da_rvalid  in  1 / da_rdata  in  DATA_W  SHALL be the read response.
REQ-014 ld_valid  out  1 / ld_data  out  DATA_W  SHALL be the extended load result.
REQ-015 busy  out  1  SHALL be the stall to upstream; ale  out  1  SHALL be the alignment-error pulse.

Function
REQ-016 FSM SHALL have states IDLE, REQ, WAIT; busy = (state != IDLE).
REQ-017 In IDLE, an ex_valid with is_load|is_store SHALL latch the operation; with both set, the operation SHALL be treated as a store.
REQ-018 Misaligned operation (addr mod 2^size != 0), or size > OW, SHALL pulse ale for one cycle at t+1, issue no request, and remain in IDLE.
REQ-019 Legal operation at cycle t SHALL enter REQ and drive the request from t+1.
REQ-020 da_addr SHALL be addr with the low OW bits cleared.
REQ-021 Enable mask SHALL be ((1<<2^size)-1) << addr[OW-1:0], driven on da_wen (store) or da_ren (load), the other enable 0.
REQ-022 da_wdata SHALL be the low 2^size bytes of wdata replicated across all lanes.
REQ-023 In REQ, the enables, address and data SHALL stay stable until a cycle with da_ready=1.
REQ-024 On acceptance, a store SHALL return to IDLE and a load SHALL enter WAIT; enables SHALL be 0 from the next cycle.
REQ-025 In WAIT, da_rvalid=1 SHALL return to IDLE and, on the next cycle, pulse ld_valid for one cycle.
REQ-026 ld_data SHALL be (da_rdata >> 8*offset) truncated to 2^size bytes and sign- or zero-extended to DATA_W; it SHALL hold its value until the next ld_valid.
REQ-027 da_rvalid outside WAIT SHALL be ignored.
REQ-028 ex_valid while busy=1 SHALL be ignored; upstream SHALL stall on busy.
REQ-029 da_ready and da_rvalid in the same WAIT-entry cycle SHALL NOT complete the load; the response SHALL be taken only in WAIT.
REQ-030 da_ren/da_wen SHALL be nonzero only in REQ.

Reset
REQ-031 rst=1 SHALL force IDLE at the next edge and zero every output: da_ren, da_wen, da_addr, da_wdata, ld_valid, ld_data, busy, ale.
REQ-032 Reset mid-REQ or mid-WAIT SHALL abandon the operation; a response arriving later SHALL be ignored per REQ-027.

Verification
REQ-033 DATA_W=32, store byte at addr 0x1003, wdata 0xA5, da_ready=1 -> at t+1: da_addr 0x1000, da_wen 4'b1000, da_wdata 0xA5A5A5A5; at t+2: busy=0, da_wen=0.
REQ-034 Signed load half at addr 0x2002, da_ready=0 for 3 cycles, then 1; rdata 0x8001_1234 one cycle later -> da_ren 4'b1100 held for 4 cycles; ld_valid pulse with ld_data 0xFFFF8001.
REQ-035 Load word at addr 0x3001 -> ale=1 at t+1 only; da_ren=0 throughout; busy=0.
REQ-036 rst asserted while in WAIT, then da_rvalid=1 -> all outputs 0 after reset; no ld_valid.
REQ-037 DATA_W=64, zero-extended load byte at addr 0x47, rdata 0x9A00_0000_0000_0000 -> da_ren 8'h80, da_addr 0x40, ld_data 0x9A.
REQ-038 Second ex_valid issued while busy=1 -> ignored; exactly one bus request is observed.
